dash_annunciator: RTL

- Downstream stage of the dashboard indicator logic: takes its two raw warning levels and drives the two board LEDs plus a buzzer.
- Uses annunciator-style latching per channel:
  - A new warning blinks and sounds until the driver acknowledges it.
  - A warning that clears before acknowledgement stays latched, blinking slowly, until acknowledged.
- Inputs come from switch-derived logic and a push-button, so all are treated as asynchronous and synchronized inside the block.

---
 rtl/dash_annunciator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dash_annunciator.sv
// Two-channel latching annunciator that drives two lamps and a buzzer. Optional lamp_test override under DASH_LAMP_TEST_EN.
// Latency: an input change is captured at edge k and reaches the FSM at edge k+2; outputs decode registers only; no backpressure.
module dash_annunciator #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ind,
  input  logic       ack,
`ifdef DASH_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [1:0] led,
  output logic       buzzer
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALERT = 2'd1;
  localparam logic [1:0] ACKED = 2'd2;
  localparam logic [1:0] HELD  = 2'd3;

  logic [1:0]      ind_m, ind_s;
  logic            ack_m, ack_s, ack_d, ack_p;
  logic [CW-1:0]   cnt;
  logic            fph, sph, wrap;
  logic [1:0][1:0] st, st_nx;
  logic [1:0]      led_n;
  logic            buz_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ind_m <= 2'b00;
      ind_s <= 2'b00;
      ack_m <= 1'b0;
      ack_s <= 1'b0;
      ack_d <= 1'b0;
    end else begin
      ind_m <= ind;
      ind_s <= ind_m;
      ack_m <= ack;
      ack_s <= ack_m;
      ack_d <= ack_s;
    end
  end

  // One pulse per press, however long the button is held.
  assign ack_p = ack_s & ~ack_d;

  assign wrap = (cnt == CNT_MAX);

  // Free-running blink timebase; channel events never restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      fph <= 1'b0;
      sph <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        fph <= ~fph;
        if (fph) sph <= ~sph;
      end
    end
  end

  always_comb begin
    st_nx = st;
    for (int n = 0; n < 2; n++) begin
      case (st[n])
        IDLE:    if (ind_s[n]) st_nx[n] = ALERT;
        ALERT: begin
          if (ack_p)          st_nx[n] = ind_s[n] ? ACKED : IDLE;
          else if (!ind_s[n]) st_nx[n] = HELD;
        end
        ACKED:   if (!ind_s[n]) st_nx[n] = IDLE;
        default: begin
          // A returning warning beats a simultaneous acknowledge.
          if (ind_s[n])   st_nx[n] = ALERT;
          else if (ack_p) st_nx[n] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= {IDLE, IDLE};
    else     st <= st_nx;
  end

  always_comb begin
    led_n = 2'b00;
    buz_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      case (st[n])
        IDLE:    led_n[n] = 1'b0;
        ALERT:   led_n[n] = fph;
        ACKED:   led_n[n] = 1'b1;
        default: led_n[n] = sph;
      endcase
      buz_n = buz_n | (st[n] == ALERT);
    end
  end

`ifdef DASH_LAMP_TEST_EN
  logic lt_m, lt_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_m <= 1'b0;
      lt_s <= 1'b0;
    end else begin
      lt_m <= lamp_test;
      lt_s <= lt_m;
    end
  end

  assign led    = lt_s ? 2'b11 : led_n;
  assign buzzer = lt_s | buz_n;
`else
  assign led    = led_n;
  assign buzzer = buz_n;
`endif

endmodule
